// File: rtl/rx_pkg.sv
`timescale 1ns/1ps
// Shared RX definitions: sampler FSM states, legal prescale ratios, window legality helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_VOTE    = 2'd2
   } state_t;

   localparam int PRESC_8  = 8;
   localparam int PRESC_16 = 16;
   localparam int PRESC_32 = 32;

   // Smallest prescale that fits a 2H+1 sample window plus one guard edge.
   function automatic int min_prescale(input int h);
      return 2 * h + 2;
   endfunction

endpackage

// File: rtl/bit_vote.sv
`timescale 1ns/1ps
// Popcount over a sample vector with majority and disagreement flags for a 2H+1 window.
// Latency: purely combinational.
// Backpressure: none; unused sample slots must be driven to 0 by the caller.
module bit_vote #(
   parameter int NUM_SAMPLES = 3,
   parameter int CNT_W       = 3
) (
   input  logic [NUM_SAMPLES-1:0] i_samples,
   input  logic [CNT_W-1:0]       i_h,
   output logic                   o_majority,
   output logic                   o_noise
);

   logic [CNT_W-1:0] w_ones;
   logic [CNT_W-1:0] w_all;

   // Count ones, then compare against half-window and full-window sizes.
   always_comb begin
      w_ones = '0;
      for (int k = 0; k < NUM_SAMPLES; k++) begin
         w_ones = w_ones + CNT_W'(i_samples[k]);
      end
      w_all      = (i_h << 1) | CNT_W'(1);
      o_majority = (w_ones > i_h);
      o_noise    = (w_ones != '0) && (w_ones != w_all);
   end

endmodule

// File: rtl/majority_sampler.sv
`timescale 1ns/1ps
// UART RX bit sampler: captures a centred window of rx_in reads and majority-votes the bit.
// Latency: bit_valid/sampled_bit/noise_err register on the edge after edge_cnt == last is sampled.
// Backpressure: none; samp_en low or an out-of-order edge_cnt drops the partial bit silently.
module majority_sampler
   import rx_pkg::*;
#(
   parameter int NUM_SAMPLES = 3,
   parameter int PRESCALE_W  = 6,
   parameter int CNT_W       = 3
) (
   input  logic                  majority_sampler_clk,
   input  logic                  majority_sampler_rst,
   input  logic                  rx_in,
   input  logic                  samp_en,
   input  logic [PRESCALE_W-1:0] edge_cnt,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  vote_mode,
   output logic                  sampled_bit,
   output logic                  bit_valid,
   output logic                  noise_err,
   output logic                  cfg_err
);

   localparam int H_MAJ = (NUM_SAMPLES - 1) / 2;

   state_t                  r_state;
   logic [PRESCALE_W-1:0]   r_prescale_q;
   logic                    r_mode_q;
   logic [CNT_W-1:0]        r_idx;
   logic [NUM_SAMPLES-1:0]  r_samp;
   logic                    r_sampled_bit;
   logic                    r_bit_valid;
   logic                    r_noise_err;
   logic                    r_cfg_err;

   logic [CNT_W-1:0]        w_h_cfg;
   logic                    w_cfg_bad;
   logic                    w_in_bad;
   logic [CNT_W-1:0]        w_h;
   logic [PRESCALE_W-1:0]   w_centre;
   logic [PRESCALE_W-1:0]   w_first;
   logic [PRESCALE_W-1:0]   w_last;
   logic [PRESCALE_W-1:0]   w_target;
   logic                    w_collecting;
   logic                    w_capture;
   logic                    w_final;
   logic                    w_hold;
   logic [NUM_SAMPLES-1:0]  w_samp_base;
   logic [NUM_SAMPLES-1:0]  w_samp_next;
   logic                    w_majority;
   logic                    w_noise;

   // Window geometry from the latched configuration; too-small prescale degrades to one sample.
   always_comb begin
      w_h_cfg   = r_mode_q ? CNT_W'(H_MAJ) : '0;
      w_cfg_bad = (int'(r_prescale_q) < min_prescale(int'(w_h_cfg)));
      w_in_bad  = (int'(prescale) < min_prescale(vote_mode ? H_MAJ : 0));
      w_h       = w_cfg_bad ? '0 : w_h_cfg;
      w_centre  = r_prescale_q >> 1;
      w_first   = w_centre - PRESCALE_W'(w_h);
      w_last    = w_centre + PRESCALE_W'(w_h);
      w_target  = w_first + PRESCALE_W'(r_idx);
   end

   // Capture qualification; the vote sees the sample being captured this cycle.
   always_comb begin
      w_collecting = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
      w_capture    = samp_en && w_collecting && (edge_cnt == w_target);
      w_final      = w_capture && (w_target == w_last);
      w_hold       = (r_state == ST_COLLECT) && (edge_cnt == (w_target - PRESCALE_W'(1)));
      w_samp_base  = (r_state == ST_COLLECT) ? r_samp : '0;
      w_samp_next  = w_samp_base | (NUM_SAMPLES'(rx_in) << r_idx);
   end

   bit_vote #(
      .NUM_SAMPLES (NUM_SAMPLES),
      .CNT_W       (CNT_W)
   ) u_bit_vote (
      .i_samples  (w_samp_next),
      .i_h        (w_h),
      .o_majority (w_majority),
      .o_noise    (w_noise)
   );

   // Sampler FSM, configuration latch and registered vote outputs.
   always_ff @(posedge majority_sampler_clk) begin
      if (majority_sampler_rst) begin
         r_state       <= ST_IDLE;
         r_prescale_q  <= '0;
         r_mode_q      <= 1'b0;
         r_idx         <= '0;
         r_samp        <= '0;
         r_sampled_bit <= 1'b0;
         r_bit_valid   <= 1'b0;
         r_noise_err   <= 1'b0;
         r_cfg_err     <= 1'b0;
      end else begin
         r_bit_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_idx <= '0;
               if (w_capture) begin
                  r_samp  <= w_samp_next;
                  r_idx   <= CNT_W'(1);
                  r_state <= w_final ? ST_VOTE : ST_COLLECT;
               end else begin
                  // Config is frozen from the first capture so the whole window uses one geometry.
                  r_prescale_q <= prescale;
                  r_mode_q     <= vote_mode;
                  r_cfg_err    <= w_in_bad;
               end
            end
            ST_COLLECT: begin
               if (w_capture) begin
                  r_samp <= w_samp_next;
                  r_idx  <= r_idx + CNT_W'(1);
                  if (w_final) begin
                     r_state <= ST_VOTE;
                  end
               end else if (!(samp_en && w_hold)) begin
                  // Enable dropped, skipped edge or wrap: discard the partial bit.
                  r_state <= ST_IDLE;
                  r_idx   <= '0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_idx   <= '0;
            end
         endcase
         if (w_final) begin
            r_sampled_bit <= w_majority;
            r_noise_err   <= w_noise;
            r_bit_valid   <= 1'b1;
         end
      end
   end

   assign sampled_bit = r_sampled_bit;
   assign bit_valid   = r_bit_valid;
   assign noise_err   = r_noise_err;
   assign cfg_err     = r_cfg_err;

endmodule
